ecg_axis_host: RTL

Host-side AXI-Stream endpoint that drives the ECG convolution coprocessor from the opposite end of both streams. It transmits a buffered frame of N_IN input samples on its master port, terminated with TLAST. It then receives N_OUT result words on its slave port into a result buffer, checks TLAST framing, and reports completion and errors. It sits between the processor-side load/readback logic and the coprocessor's S_AXIS/M_AXIS ports, and serves as both the integration driver and the bench stimulus source.

---
 rtl/ecg_host_pkg.sv | 24 ++
 rtl/host_sdp_ram.sv | 48 ++++
 rtl/ecg_axis_host.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/ecg_host_pkg.sv
// ecg_host_pkg
//   Shared constants for the ECG coprocessor host endpoint:
//   - default widths and frame sizes (sample width, words per frame,
//     buffer address widths, receive watchdog limit)
//   - FSM state encoding, kept as plain localparam constants so that
//     existing tooling that decodes the state register keeps working.
package ecg_host_pkg;

  localparam int HOST_DATA_W         = 16;
  localparam int HOST_N_IN           = 512;
  localparam int HOST_IN_AW          = 9;
  localparam int HOST_N_OUT          = 4096;  // 8 filters x 512 samples
  localparam int HOST_OUT_AW         = 12;
  localparam int HOST_TIMEOUT_CYCLES = 65535;

  typedef logic [2:0] host_state_t;

  localparam host_state_t ST_IDLE  = 3'd0;
  localparam host_state_t ST_PRIME = 3'd1;
  localparam host_state_t ST_SEND  = 3'd2;
  localparam host_state_t ST_RECV  = 3'd3;
  localparam host_state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/host_sdp_ram.sv
// host_sdp_ram
//   Simple dual-port RAM: one write port, one read port with a registered
//   output (1-cycle latency). Written so that it maps onto block RAM.
//   A read of the address being written in the same cycle returns the
//   old contents. Only the output register is reset; the array keeps its
//   contents across reset.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset (output reg only)
//   we, waddr, wdata    write port
//   raddr, rdata        read port, rdata valid the cycle after raddr
module host_sdp_ram #(
  parameter int W     = 16,
  parameter int AW    = 9,
  parameter int DEPTH = 512
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ecg_axis_host.sv
// ecg_axis_host
//   Host-side AXI-Stream endpoint for the ECG convolution coprocessor.
//   Streams a buffered frame of N_IN samples out on M_AXIS (TLAST on the
//   final word), then collects N_OUT result words from S_AXIS into a
//   result buffer, checking TLAST framing.
//   Optional receive watchdog: define HOST_TIMEOUT_EN to enable it (adds
//   the TIMEOUT_CYCLES parameter); otherwise err_timeout is tied low and
//   the receive phase waits indefinitely.
// Ports:
//   ACLK, ARESETN                 clock, synchronous active-low reset
//   start                         begin a transaction (honoured in IDLE)
//   busy, done                    status; done pulses for one cycle
//   err_tlast, err_timeout        sticky error flags, cleared by start
//   words_rcvd                    result words accepted this transaction
//   ld_en/ld_addr/ld_data         input buffer write port (IDLE only)
//   rd_addr/rd_data               result buffer read port, 1-cycle latency
//   M_AXIS_*                      sample stream to the coprocessor
//   S_AXIS_*                      result stream from the coprocessor
module ecg_axis_host
  import ecg_host_pkg::*;
#(
  parameter int DATA_W = HOST_DATA_W,
  parameter int N_IN   = HOST_N_IN,
  parameter int IN_AW  = HOST_IN_AW,
  parameter int N_OUT  = HOST_N_OUT,
  parameter int OUT_AW = HOST_OUT_AW
`ifdef HOST_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = HOST_TIMEOUT_CYCLES
`endif
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              err_tlast,
  output logic              err_timeout,
  output logic [OUT_AW:0]   words_rcvd,
  input  logic              ld_en,
  input  logic [IN_AW-1:0]  ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [OUT_AW-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              M_AXIS_TVALID,
  output logic [DATA_W-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TLAST,
  input  logic              M_AXIS_TREADY,
  input  logic              S_AXIS_TVALID,
  input  logic [DATA_W-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TLAST,
  output logic              S_AXIS_TREADY
);

  localparam logic [IN_AW-1:0]  LAST_IN  = IN_AW'(N_IN - 1);
  localparam logic [OUT_AW-1:0] LAST_OUT = OUT_AW'(N_OUT - 1);

  host_state_t       state_q, state_d;
  logic [IN_AW-1:0]  in_idx_q, in_idx_d;
  logic [OUT_AW-1:0] out_idx_q, out_idx_d;
  logic              err_tlast_q, err_tlast_d;
  logic [OUT_AW:0]   words_rcvd_q, words_rcvd_d;

  logic              m_fire, s_fire, in_we;
  logic [IN_AW-1:0]  in_raddr;
  logic [DATA_W-1:0] in_rdata;

  assign M_AXIS_TVALID = (state_q == ST_SEND);
  assign M_AXIS_TLAST  = M_AXIS_TVALID && (in_idx_q == LAST_IN);
  // The RAM output register keeps reading outside SEND; mask it so the
  // bus idles at zero.
  assign M_AXIS_TDATA  = M_AXIS_TVALID ? in_rdata : '0;
  assign S_AXIS_TREADY = (state_q == ST_RECV);

  assign m_fire = M_AXIS_TVALID & M_AXIS_TREADY;
  assign s_fire = S_AXIS_TVALID & S_AXIS_TREADY;
  assign in_we  = ld_en && (state_q == ST_IDLE);
  // Look one word ahead on a fire so the registered read is ready for the
  // next beat; on a stall the address holds and TDATA stays put.
  assign in_raddr = in_idx_q + IN_AW'(m_fire);

  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);
  assign err_tlast  = err_tlast_q;
  assign words_rcvd = words_rcvd_q;

`ifdef HOST_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            err_timeout_q, err_timeout_d;
  logic            wdog_expire;

  // Expires on the idle cycle that would bring the count to TIMEOUT_CYCLES.
  assign wdog_expire = (state_q == ST_RECV) && !s_fire &&
                       (wdog_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    in_idx_d     = in_idx_q;
    out_idx_d    = out_idx_q;
    err_tlast_d  = err_tlast_q;
    words_rcvd_d = words_rcvd_q;
`ifdef HOST_TIMEOUT_EN
    wdog_d        = wdog_q;
    err_timeout_d = err_timeout_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_PRIME;
          in_idx_d     = '0;
          out_idx_d    = '0;
          err_tlast_d  = 1'b0;
          words_rcvd_d = '0;
`ifdef HOST_TIMEOUT_EN
          wdog_d        = '0;
          err_timeout_d = 1'b0;
`endif
        end
      end
      ST_PRIME: state_d = ST_SEND;
      ST_SEND: begin
        if (m_fire) begin
          in_idx_d = in_idx_q + 1'b1;
          if (in_idx_q == LAST_IN) begin
            state_d = ST_RECV;
          end
        end
      end
      ST_RECV: begin
        if (s_fire) begin
          out_idx_d    = out_idx_q + 1'b1;
          words_rcvd_d = words_rcvd_q + 1'b1;
          // End the frame on TLAST or on the final slot, whichever comes
          // first; only both together is a clean completion.
          if (S_AXIS_TLAST || (out_idx_q == LAST_OUT)) begin
            state_d = ST_DONE;
            if (!(S_AXIS_TLAST && (out_idx_q == LAST_OUT))) begin
              err_tlast_d = 1'b1;
            end
          end
`ifdef HOST_TIMEOUT_EN
          wdog_d = '0;
        end else if (wdog_expire) begin
          err_timeout_d = 1'b1;
          state_d       = ST_DONE;
        end else begin
          wdog_d = wdog_q + 1'b1;
`endif
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q      <= ST_IDLE;
      in_idx_q     <= '0;
      out_idx_q    <= '0;
      err_tlast_q  <= 1'b0;
      words_rcvd_q <= '0;
    end else begin
      state_q      <= state_d;
      in_idx_q     <= in_idx_d;
      out_idx_q    <= out_idx_d;
      err_tlast_q  <= err_tlast_d;
      words_rcvd_q <= words_rcvd_d;
    end
  end

`ifdef HOST_TIMEOUT_EN
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      wdog_q        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      err_timeout_q <= err_timeout_d;
    end
  end
`endif

  host_sdp_ram #(.W(DATA_W), .AW(IN_AW), .DEPTH(N_IN)) u_in_buf (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .we    (in_we),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (in_raddr),
    .rdata (in_rdata)
  );

  host_sdp_ram #(.W(DATA_W), .AW(OUT_AW), .DEPTH(N_OUT)) u_out_buf (
    .clk   (ACLK),
    .rst_n (ARESETN),
    .we    (s_fire),
    .waddr (out_idx_q),
    .wdata (S_AXIS_TDATA),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule
